// File: rtl/clock_meas_pkg.sv
// Shared types for the clock period meter.
// State encoding, default width and result bundle.
package clock_meas_pkg;

  localparam int DEF_WIDTH = 24;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    HIGH,
    LOW,
    STALL
  } meas_state_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] hi;
    logic [DEF_WIDTH-1:0] lo;
  } result_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizer for an async level plus edge strobes.
// Rise and fall share one latency so phase counts stay exact.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              level_d;

  // shift the input through the chain, keep one delayed copy
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      level_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], async_in};
      level_d <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~level_d;
  assign fall  = ~level & level_d;

endmodule

// File: rtl/clock_period_meter.sv
// Measures high/low phase lengths of a slow clock.
// Results leave through a valid/ready port with lock flags.
module clock_period_meter
  import clock_meas_pkg::*;
#(
  parameter int          WIDTH          = DEF_WIDTH,
  parameter int          SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             clock_meas,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] period_hi,
  output logic [WIDTH-1:0] period_lo,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             locked,
  output logic             timeout,
  output logic             overrun
);

  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } res_t;

  localparam logic [WIDTH-1:0] TMO = WIDTH'(TIMEOUT_CYCLES);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic s;
  logic rise;
  logic fall;

  meas_state_t state;
  meas_state_t state_n;

  logic [WIDTH-1:0] hi_cnt;
  logic [WIDTH-1:0] lo_cnt;

  logic hi_start;
  logic hi_inc;
  logic lo_start;
  logic lo_inc;
  logic publish;
  logic stall_hit;

  res_t cur_res;
  res_t held_res;
  res_t last_res;
  logic primed;

  sync_edge_detect #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .async_in (clock_meas),
    .level    (s),
    .rise     (rise),
    .fall     (fall)
  );

  assign cur_res = '{hi: hi_cnt, lo: lo_cnt};

  // state register
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // next state and datapath strobes
  always_comb begin
    state_n   = state;
    hi_start  = 1'b0;
    hi_inc    = 1'b0;
    lo_start  = 1'b0;
    lo_inc    = 1'b0;
    publish   = 1'b0;
    stall_hit = 1'b0;
    if (!enable) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: state_n = ALIGN;
        ALIGN: begin
          if (rise) begin
            state_n  = HIGH;
            hi_start = 1'b1;
          end
        end
        HIGH: begin
          if (hi_cnt == TMO) begin
            state_n   = STALL;
            stall_hit = 1'b1;
          end else if (fall) begin
            state_n  = LOW;
            lo_start = 1'b1;
          end else begin
            hi_inc = s;
          end
        end
        LOW: begin
          if (lo_cnt == TMO) begin
            state_n   = STALL;
            stall_hit = 1'b1;
          end else if (rise) begin
            state_n  = HIGH;
            publish  = 1'b1;
            hi_start = 1'b1;
          end else begin
            lo_inc = ~s;
          end
        end
        STALL: begin
          if (rise) begin
            state_n  = HIGH;
            hi_start = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // saturating phase counters, dropped when measurement stops
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      hi_cnt <= '0;
      lo_cnt <= '0;
    end else if (state_n == IDLE) begin
      hi_cnt <= '0;
      lo_cnt <= '0;
    end else begin
      if (hi_start)
        hi_cnt <= ONE;
      else if (hi_inc && hi_cnt != CNT_MAX)
        hi_cnt <= hi_cnt + ONE;
      if (lo_start)
        lo_cnt <= ONE;
      else if (lo_inc && lo_cnt != CNT_MAX)
        lo_cnt <= lo_cnt + ONE;
    end
  end

  // result register and valid/ready handshake
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      held_res   <= '0;
      meas_valid <= 1'b0;
    end else if (publish && (!meas_valid || meas_ready)) begin
      held_res   <= cur_res;
      meas_valid <= 1'b1;
    end else if (meas_valid && meas_ready) begin
      meas_valid <= 1'b0;
    end
  end

  assign period_hi = held_res.hi;
  assign period_lo = held_res.lo;

  // lock tracks consecutive computed results
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      locked   <= 1'b0;
      primed   <= 1'b0;
      last_res <= '0;
    end else if (!enable || stall_hit || state == IDLE) begin
      locked <= 1'b0;
      primed <= 1'b0;
    end else if (publish) begin
      locked   <= primed && (cur_res == last_res);
      primed   <= 1'b1;
      last_res <= cur_res;
    end
  end

  // sticky flags, a set beats a same-cycle clear
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      timeout <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (stall_hit)  timeout <= 1'b1;
      else if (clear) timeout <= 1'b0;
      if (publish && meas_valid && !meas_ready)
        overrun <= 1'b1;
      else if (clear)
        overrun <= 1'b0;
    end
  end

endmodule
